// File: rtl/nabp_image_addresser_multi.sv
`default_nettype none
// ============================================================================
// Module      : nabp_image_addresser_multi
// Description : Image-RAM address generator for the PE domino-chain readout.
//               Walks each partition of an N x N row-major image in X scan,
//               Y scan, or both, one address per enabled cycle. A kick
//               starts a run after a programmable delay. Abort returns to
//               idle at any time.
// Optional    : define NABP_ADDR_MIRROR_EN to add the ir_mirror input, which
//               reverses the position order within every line.
// Ports       : clk, reset_n (async, active low)
//               ir_kick, ir_mode[1:0], ir_enable, ir_abort  - control inputs
//               ir_mirror                                  - only with mirror
//               ir_kick_ack   - pulse on the last delay cycle
//               ir_addr       - registered image address
//               ir_addr_valid - high while addressing
//               ir_scan_mode  - 0 X scan, 1 Y scan
//               ir_done       - pulse after the final address is consumed
// Revision    : 1.0 - initial release
// ============================================================================
module nabp_image_addresser_multi #(
  parameter int IMAGE_SIZE     = 128,
  parameter int PARTITION_SIZE = 16,
  parameter int DELAY_CYCLES   = 8,
  parameter int ADDR_WIDTH     = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ir_kick,
  input  logic [1:0]            ir_mode,
  input  logic                  ir_enable,
  input  logic                  ir_abort,
`ifdef NABP_ADDR_MIRROR_EN
  input  logic                  ir_mirror,
`endif
  output logic                  ir_kick_ack,
  output logic [ADDR_WIDTH-1:0] ir_addr,
  output logic                  ir_addr_valid,
  output logic                  ir_scan_mode,
  output logic                  ir_done
);

  localparam int NP  = IMAGE_SIZE / PARTITION_SIZE;
  localparam int P_W = (NP > 1) ? $clog2(NP) : 1;
  localparam int L_W = (PARTITION_SIZE > 1) ? $clog2(PARTITION_SIZE) : 1;
  localparam int S_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int D_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

  localparam logic [P_W-1:0] P_LAST = P_W'(NP - 1);
  localparam logic [L_W-1:0] L_LAST = L_W'(PARTITION_SIZE - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(IMAGE_SIZE - 1);
  localparam logic [D_W-1:0] D_LAST = D_W'(DELAY_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] N_A  = ADDR_WIDTH'(IMAGE_SIZE);
  localparam logic [ADDR_WIDTH-1:0] PS_A = ADDR_WIDTH'(PARTITION_SIZE);

  generate
    if (IMAGE_SIZE % PARTITION_SIZE != 0) begin : g_size_check
      $error("IMAGE_SIZE must be a multiple of PARTITION_SIZE");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_ADDR_X, S_ADDR_Y} state_t;

  state_t                  state, state_n;
  logic [P_W-1:0]          p, p_n;
  logic [L_W-1:0]          l, l_n;
  logic [S_W-1:0]          s, s_n, s_eff;
  logic [D_W-1:0]          d, d_n;
  logic [1:0]              mode, mode_n;
  logic                    mirror, mirror_n, mirror_in;
  logic                    done_n;
  logic [ADDR_WIDTH-1:0]   addr_n;

`ifdef NABP_ADDR_MIRROR_EN
  assign mirror_in = ir_mirror;
`else
  assign mirror_in = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      p       <= '0;
      l       <= '0;
      s       <= '0;
      d       <= '0;
      mode    <= '0;
      mirror  <= 1'b0;
      ir_addr <= '0;
      ir_done <= 1'b0;
    end else begin
      state   <= state_n;
      p       <= p_n;
      l       <= l_n;
      s       <= s_n;
      d       <= d_n;
      mode    <= mode_n;
      mirror  <= mirror_n;
      ir_addr <= addr_n;
      ir_done <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    p_n      = p;
    l_n      = l;
    s_n      = s;
    d_n      = d;
    mode_n   = mode;
    mirror_n = mirror;
    done_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (ir_kick) begin
          state_n  = S_DELAY;
          d_n      = '0;
          // Mode 11 is stored as 00 so later decisions see only three modes.
          mode_n   = (ir_mode == 2'b11) ? 2'b00 : ir_mode;
          mirror_n = mirror_in;
        end
      end
      S_DELAY: begin
        if (d == D_LAST) begin
          d_n     = '0;
          state_n = (mode == 2'b10) ? S_ADDR_Y : S_ADDR_X;
        end else begin
          d_n = d + 1'b1;
        end
      end
      default: begin
        if (ir_enable) begin
          if (s != S_LAST) begin
            s_n = s + 1'b1;
          end else begin
            s_n = '0;
            if (l != L_LAST) begin
              l_n = l + 1'b1;
            end else begin
              l_n = '0;
              // Combined mode runs the Y phase of the same partition next.
              if (state == S_ADDR_X && mode == 2'b00) begin
                state_n = S_ADDR_Y;
              end else if (p == P_LAST) begin
                state_n = S_IDLE;
                p_n     = '0;
                done_n  = 1'b1;
              end else begin
                p_n     = p + 1'b1;
                state_n = (mode == 2'b10) ? S_ADDR_Y : S_ADDR_X;
              end
            end
          end
        end
      end
    endcase
    if (ir_abort) begin
      state_n = S_IDLE;
      p_n     = '0;
      l_n     = '0;
      s_n     = '0;
      d_n     = '0;
      done_n  = 1'b0;
    end
  end

  // The address register is loaded from the next counter values, so the
  // first address is already present on the first ADDR cycle.
  always_comb begin
    s_eff  = mirror_n ? (S_LAST - s_n) : s_n;
    addr_n = '0;
    if (state_n == S_ADDR_Y) begin
      addr_n = ADDR_WIDTH'(s_eff) * N_A + ADDR_WIDTH'(p_n) * PS_A + ADDR_WIDTH'(l_n);
    end else if (state_n != S_IDLE) begin
      addr_n = (ADDR_WIDTH'(p_n) * PS_A + ADDR_WIDTH'(l_n)) * N_A + ADDR_WIDTH'(s_eff);
    end
  end

  assign ir_kick_ack   = (state == S_DELAY) && (d == D_LAST) && !ir_abort;
  assign ir_addr_valid = (state == S_ADDR_X) || (state == S_ADDR_Y);
  assign ir_scan_mode  = (state == S_ADDR_Y);

endmodule
`default_nettype wire

// File: tb/tb_nabp_image_addresser_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_nabp_image_addresser_multi
// Description : Directed self-checking bench, N=8, PS=4, delay 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nabp_image_addresser_multi;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ir_kick, ir_enable, ir_abort;
  logic [1:0] ir_mode;
`ifdef NABP_ADDR_MIRROR_EN
  logic       ir_mirror;
`endif
  logic       ir_kick_ack, ir_addr_valid, ir_scan_mode, ir_done;
  logic [5:0] ir_addr;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  nabp_image_addresser_multi #(
    .IMAGE_SIZE(8), .PARTITION_SIZE(4), .DELAY_CYCLES(2), .ADDR_WIDTH(6)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ir_kick(ir_kick), .ir_mode(ir_mode),
    .ir_enable(ir_enable), .ir_abort(ir_abort),
`ifdef NABP_ADDR_MIRROR_EN
    .ir_mirror(ir_mirror),
`endif
    .ir_kick_ack(ir_kick_ack), .ir_addr(ir_addr), .ir_addr_valid(ir_addr_valid),
    .ir_scan_mode(ir_scan_mode), .ir_done(ir_done)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Kick and wait until the first address is presented (3 edges).
  task automatic start_run(input logic [1:0] m, input logic en);
    ir_mode = m; ir_kick = 1'b1; ir_enable = en;
    step();
    ir_kick = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset;
    nvec++;
    if ({ir_kick_ack, ir_addr, ir_addr_valid, ir_scan_mode, ir_done} !== 10'd0) begin
      nerr++;
      $display("FAIL reset_outputs got %b required 0",
               {ir_kick_ack, ir_addr, ir_addr_valid, ir_scan_mode, ir_done});
    end
  endtask

  task automatic test_x_then_y;
    logic [5:0] e;
    logic       sm;
    ir_mode = 2'b00; ir_kick = 1'b1; ir_enable = 1'b1;
    step();
    ir_kick = 1'b0;
    nvec++;
    if (ir_kick_ack !== 1'b0) begin nerr++; $display("FAIL ack_early got %b required 0", ir_kick_ack); end
    step();
    nvec++;
    if (ir_kick_ack !== 1'b1) begin nerr++; $display("FAIL ack_pulse got %b required 1", ir_kick_ack); end
    step();
    for (int p = 0; p < 2; p++)
      for (int ph = 0; ph < 2; ph++)
        for (int l = 0; l < 4; l++)
          for (int s = 0; s < 8; s++) begin
            e  = (ph == 0) ? 6'((p*4 + l)*8 + s) : 6'(s*8 + p*4 + l);
            sm = (ph != 0);
            nvec++;
            if (ir_addr !== e || ir_addr_valid !== 1'b1 || ir_scan_mode !== sm || ir_done !== 1'b0) begin
              nerr++;
              $display("FAIL xy_seq p%0d ph%0d l%0d s%0d got addr %0d v%b sm%b d%b required addr %0d v1 sm%b d0",
                       p, ph, l, s, ir_addr, ir_addr_valid, ir_scan_mode, ir_done, e, sm);
            end
            step();
          end
    nvec++;
    if (ir_done !== 1'b1 || ir_addr_valid !== 1'b0) begin
      nerr++; $display("FAIL xy_done got done %b valid %b required 1 0", ir_done, ir_addr_valid);
    end
    step();
    nvec++;
    if (ir_done !== 1'b0) begin nerr++; $display("FAIL xy_done_pulse got %b required 0", ir_done); end
  endtask

  task automatic test_enable_toggle;
    logic [3:0]  en_pat;
    logic [5:0]  exp_a [5];
    exp_a = '{6'd0, 6'd1, 6'd1, 6'd1, 6'd2};
    en_pat = 4'b1001;
    start_run(2'b01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if (ir_addr !== exp_a[i] || ir_addr_valid !== 1'b1) begin
        nerr++;
        $display("FAIL enable_toggle[%0d] got addr %0d v%b required %0d v1", i, ir_addr, ir_addr_valid, exp_a[i]);
      end
      if (i < 4) ir_enable = en_pat[3-i];
      else       ir_enable = 1'b0;
      step();
    end
    ir_abort = 1'b1;
    step();
    ir_abort = 1'b0;
  endtask

  task automatic test_single_modes;
    logic [5:0] e;
    start_run(2'b01, 1'b1);
    for (int i = 0; i < 64; i++) begin
      nvec++;
      if (ir_addr !== 6'(i) || ir_addr_valid !== 1'b1 || ir_scan_mode !== 1'b0) begin
        nerr++;
        $display("FAIL mode_x[%0d] got addr %0d v%b sm%b required %0d v1 sm0", i, ir_addr, ir_addr_valid, ir_scan_mode, i);
      end
      step();
    end
    nvec++;
    if (ir_done !== 1'b1) begin nerr++; $display("FAIL mode_x_done got %b required 1", ir_done); end
    start_run(2'b10, 1'b1);
    for (int p = 0; p < 2; p++)
      for (int l = 0; l < 4; l++)
        for (int s = 0; s < 8; s++) begin
          e = 6'(s*8 + p*4 + l);
          nvec++;
          if (ir_addr !== e || ir_addr_valid !== 1'b1 || ir_scan_mode !== 1'b1) begin
            nerr++;
            $display("FAIL mode_y p%0d l%0d s%0d got addr %0d v%b sm%b required %0d v1 sm1",
                     p, l, s, ir_addr, ir_addr_valid, ir_scan_mode, e);
          end
          step();
        end
    nvec++;
    if (ir_done !== 1'b1) begin nerr++; $display("FAIL mode_y_done got %b required 1", ir_done); end
    // Mode 11 behaves as 00: X phase of partition 0, then Y.
    start_run(2'b11, 1'b1);
    for (int i = 0; i < 32; i++) step();
    nvec++;
    if (ir_addr !== 6'd0 || ir_scan_mode !== 1'b1 || ir_addr_valid !== 1'b1) begin
      nerr++;
      $display("FAIL mode_11 got addr %0d sm%b v%b required 0 sm1 v1", ir_addr, ir_scan_mode, ir_addr_valid);
    end
    ir_abort = 1'b1;
    step();
    ir_abort = 1'b0;
  endtask

  task automatic test_abort;
    start_run(2'b00, 1'b1);
    for (int i = 0; i < 41; i++) step();
    nvec++;
    if (ir_addr !== 6'd9 || ir_scan_mode !== 1'b1) begin
      nerr++; $display("FAIL abort_pre got addr %0d sm%b required 9 sm1", ir_addr, ir_scan_mode);
    end
    ir_abort = 1'b1;
    step();
    ir_abort = 1'b0;
    nvec++;
    if (ir_addr_valid !== 1'b0 || ir_done !== 1'b0 || ir_addr !== 6'd0) begin
      nerr++;
      $display("FAIL abort_idle got v%b d%b addr %0d required v0 d0 addr 0", ir_addr_valid, ir_done, ir_addr);
    end
    step();
    nvec++;
    if (ir_done !== 1'b0) begin nerr++; $display("FAIL abort_no_done got %b required 0", ir_done); end
    // Kick together with abort must not start a run.
    ir_kick = 1'b1; ir_abort = 1'b1;
    step();
    ir_kick = 1'b0; ir_abort = 1'b0;
    nvec++;
    if (ir_kick_ack !== 1'b0 || ir_addr_valid !== 1'b0) begin
      nerr++; $display("FAIL abort_kick_a got ack %b v%b required 0 0", ir_kick_ack, ir_addr_valid);
    end
    step();
    nvec++;
    if (ir_kick_ack !== 1'b0 || ir_addr_valid !== 1'b0) begin
      nerr++; $display("FAIL abort_kick_b got ack %b v%b required 0 0", ir_kick_ack, ir_addr_valid);
    end
    step();
    start_run(2'b00, 1'b0);
    nvec++;
    if (ir_addr !== 6'd0 || ir_addr_valid !== 1'b1 || ir_scan_mode !== 1'b0) begin
      nerr++;
      $display("FAIL restart got addr %0d v%b sm%b required 0 v1 sm0", ir_addr, ir_addr_valid, ir_scan_mode);
    end
    ir_abort = 1'b1;
    step();
    ir_abort = 1'b0;
  endtask

  task automatic test_async_reset;
    start_run(2'b01, 1'b1);
    for (int i = 0; i < 5; i++) step();
    ir_kick = 1'b1;
    step();
    ir_kick = 1'b0;
    step();
    nvec++;
    if (ir_addr !== 6'd7 || ir_addr_valid !== 1'b1) begin
      nerr++; $display("FAIL kick_ignored got addr %0d v%b required 7 v1", ir_addr, ir_addr_valid);
    end
    #3 reset_n = 1'b0;
    #1;
    nvec++;
    if ({ir_kick_ack, ir_addr, ir_addr_valid, ir_scan_mode, ir_done} !== 10'd0) begin
      nerr++;
      $display("FAIL async_reset got %b required 0",
               {ir_kick_ack, ir_addr, ir_addr_valid, ir_scan_mode, ir_done});
    end
    #2 reset_n = 1'b1;
    step();
  endtask

`ifdef NABP_ADDR_MIRROR_EN
  task automatic test_mirror;
    ir_mirror = 1'b1;
    start_run(2'b01, 1'b1);
    ir_mirror = 1'b0;
    for (int i = 0; i < 16; i++) begin
      nvec++;
      if (ir_addr !== 6'((i/8)*8 + 7 - (i%8))) begin
        nerr++;
        $display("FAIL mirror[%0d] got %0d required %0d", i, ir_addr, (i/8)*8 + 7 - (i%8));
      end
      step();
    end
    ir_abort = 1'b1;
    step();
    ir_abort = 1'b0;
  endtask
`endif

  initial begin
    reset_n = 1'b0; ir_kick = 1'b0; ir_mode = 2'b00; ir_enable = 1'b0; ir_abort = 1'b0;
`ifdef NABP_ADDR_MIRROR_EN
    ir_mirror = 1'b0;
`endif
    #2;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    test_reset();
    test_x_then_y();
    test_enable_toggle();
    test_single_modes();
    test_abort();
    test_async_reset();
`ifdef NABP_ADDR_MIRROR_EN
    test_mirror();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
